// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register slave:
//   - AXI response codes (EXOKAY 2'b01 and DECERR 2'b11 are reserved, not used)
//   - write and read handshake state encodings
//   - ADDR_LSB: byte-address bits below the 32-bit word index
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_LSB = 2;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
// Bank of NUM_REGS registers with one byte-strobed write port, one
// combinational read port and a flattened export of every register.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears all registers)
//   we          write enable for this cycle
//   widx        register index written
//   wdata/wstrb write data and byte-lane enables
//   ridx        register index read
//   rdata       combinational read data
//   regs_flat   register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
module axi_lite_regfile #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_W-1:0]               widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic [IDX_W-1:0]               ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Only the byte lanes with a set strobe are overwritten; the rest keep
    // their previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) begin
                    regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read returns the pre-write value during a commit cycle, which gives
    // the "old value wins" behaviour for a simultaneous read and write.
    assign rdata = regs[ridx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
// AXI4-Lite slave terminating single-beat reads and writes into a bank of
// NUM_REGS 32-bit registers. One outstanding transaction per direction;
// the read and write paths run independently.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   aw*/w*/b*                     write address, data and response channels
//   ar*/r*                        read address and data channels
//   regs_flat                     all register contents, reg i at [i*32 +: 32]
//   wr_pulse                      one-cycle pulse on the register just written
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    // Anything at or above NUM_REGS*4 has a nonzero bit above the word index.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (ADDR_LSB + IDX_W)) == '0;
    endfunction

    // Byte offset within a word carries no meaning for 32-bit registers.
    logic unused_low_bits;
    assign unused_low_bits = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    wstate_t               w_state, w_state_next;
    rstate_t               r_state, r_state_next;

    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic                  aw_ok_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  commit;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_rdata;

    // Commit happens in the first cycle where both halves of the write are held.
    assign commit = (w_state == W_IDLE) && aw_held && w_held;
    assign rf_we  = commit && aw_ok_q;

    axi_lite_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .widx      (aw_idx_q),
        .wdata     (w_data_q),
        .wstrb     (w_strb_q),
        .ridx      (araddr[ADDR_LSB +: IDX_W]),
        .rdata     (rf_rdata),
        .regs_flat (regs_flat)
    );

    // ---------------- write path ----------------

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (commit)           w_state_next = W_RESP;
            W_RESP:  if (bvalid && bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // AW and W are captured independently; each ready drops once its own
    // channel is held and comes back only after the B handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            aw_ok_q  <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        bvalid  <= 1'b1;
                        if (aw_ok_q) begin
                            bresp    <= RESP_OKAY;
                            wr_pulse <= NUM_REGS'(1) << aw_idx_q;
                        end else begin
                            bresp    <= RESP_SLVERR;
                        end
                    end else begin
                        if (awvalid && awready) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= awaddr[ADDR_LSB +: IDX_W];
                            aw_ok_q  <= addr_in_range(awaddr);
                            awready  <= 1'b0;
                        end else if (!aw_held) begin
                            awready  <= 1'b1;
                        end
                        if (wvalid && wready) begin
                            w_held   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                            wready   <= 1'b0;
                        end else if (!w_held) begin
                            wready   <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- read path ----------------

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid && arready) r_state_next = R_DATA;
            R_DATA:  if (rready)             r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read data is registered at the AR handshake and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        if (addr_in_range(araddr)) begin
                            rdata <= rf_rdata;
                            rresp <= RESP_OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs
// Directed bench for axi_lite_slave_regs (NUM_REGS=8). Inputs change 1 ns
// after each rising edge; outputs are sampled at the same point.
module tb_axi_lite_slave_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  awaddr, wdata, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] regs_flat;
    logic [7:0]   wr_pulse;

    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  model [8];

    axi_lite_slave_regs #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .regs_flat (regs_flat),
        .wr_pulse  (wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic applyStimulus(input logic awv, input logic [31:0] a,
                                 input logic wv, input logic [31:0] d,
                                 input logic [3:0] s);
        awvalid = awv;
        awaddr  = a;
        wvalid  = wv;
        wdata   = d;
        wstrb   = s;
    endtask

    task automatic checkRegs(input string tag);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("%s_reg%0d", tag, i), regs_flat[i*32 +: 32], model[i]);
        end
    endtask

    // AW and W in the same cycle; response expected exactly one cycle later.
    task automatic writeBoth(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp,
                             input logic [7:0] exp_pulse, input string tag);
        checkOutput({tag, "_awready"}, 32'(awready), 32'd1);
        checkOutput({tag, "_wready"}, 32'(wready), 32'd1);
        applyStimulus(1'b1, a, 1'b1, d, s);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        checkOutput({tag, "_bvalid_early"}, 32'(bvalid), 32'd0);
        tick();
        checkOutput({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        checkOutput({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        checkOutput({tag, "_pulse"}, 32'(wr_pulse), 32'(exp_pulse));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput({tag, "_bvalid_done"}, 32'(bvalid), 32'd0);
    endtask

    task automatic readCheck(input logic [31:0] a, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, input string tag);
        checkOutput({tag, "_arready"}, 32'(arready), 32'd1);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        checkOutput({tag, "_rdata"}, rdata, exp_data);
        checkOutput({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput({tag, "_rvalid_done"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        bready = 1'b0; arvalid = 1'b0; araddr = 32'd0; rready = 1'b0;

        // reset state
        tick(); tick(); tick();
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_arready", 32'(arready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_pulse", 32'(wr_pulse), 32'd0);
        checkRegs("rst");
        rst = 1'b0;
        tick();
        checkOutput("post_rst_awready", 32'(awready), 32'd1);
        checkOutput("post_rst_wready", 32'(wready), 32'd1);
        checkOutput("post_rst_arready", 32'(arready), 32'd1);

        // AW first to 0x04, W two cycles later
        applyStimulus(1'b1, 32'h04, 1'b0, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        checkOutput("t1_awready_drop", 32'(awready), 32'd0);
        checkOutput("t1_wready_hold", 32'(wready), 32'd1);
        tick(); tick();
        checkOutput("t1_bvalid_wait", 32'(bvalid), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 32'hDEADBEEF, 4'hF);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        checkOutput("t1_bvalid_early", 32'(bvalid), 32'd0);
        tick();
        model[1] = 32'hDEADBEEF;
        checkOutput("t1_bvalid", 32'(bvalid), 32'd1);
        checkOutput("t1_bresp", 32'(bresp), 32'd0);
        checkOutput("t1_pulse", 32'(wr_pulse), 32'h02);
        checkOutput("t1_reg1", regs_flat[32 +: 32], model[1]);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("t1_bvalid_done", 32'(bvalid), 32'd0);
        checkOutput("t1_pulse_done", 32'(wr_pulse), 32'd0);
        checkOutput("t1_awready_back", 32'(awready), 32'd1);
        readCheck(32'h04, 32'hDEADBEEF, 2'b00, "t1_rd");

        // W before AW to 0x1C
        applyStimulus(1'b0, 32'd0, 1'b1, 32'hDEADBEEF, 4'hF);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        checkOutput("t2_wready_drop", 32'(wready), 32'd0);
        checkOutput("t2_awready_hold", 32'(awready), 32'd1);
        tick();
        checkOutput("t2_bvalid_wait", 32'(bvalid), 32'd0);
        applyStimulus(1'b1, 32'h1C, 1'b0, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        checkOutput("t2_bvalid_early", 32'(bvalid), 32'd0);
        tick();
        model[7] = 32'hDEADBEEF;
        checkOutput("t2_bvalid", 32'(bvalid), 32'd1);
        checkOutput("t2_pulse", 32'(wr_pulse), 32'h80);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // AW and W together to 0x08
        writeBoth(32'h08, 32'h12345678, 4'hF, 2'b00, 8'h04, "t2b");
        model[2] = 32'h12345678;
        checkRegs("t2");

        // partial strobe on reg1
        writeBoth(32'h04, 32'hAAAA5555, 4'b0011, 2'b00, 8'h02, "t3");
        model[1] = 32'hDEAD5555;
        readCheck(32'h04, 32'hDEAD5555, 2'b00, "t3_rd");

        // zero strobe still pulses and answers OKAY, changes nothing
        writeBoth(32'h0C, 32'h11111111, 4'h0, 2'b00, 8'h08, "t3z");
        checkRegs("t3z");

        // out of range write and read
        writeBoth(32'h20, 32'hFFFFFFFF, 4'hF, 2'b10, 8'h00, "t4");
        checkRegs("t4");
        readCheck(32'h40, 32'h0, 2'b10, "t4_rd");
        readCheck(32'h1F, 32'hDEADBEEF, 2'b00, "t4_lowbits");

        // commit and AR on the same register in the same cycle: old value
        applyStimulus(1'b1, 32'h14, 1'b1, 32'h77777777, 4'hF);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        araddr  = 32'h14;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model[5] = 32'h77777777;
        checkOutput("t5c_bvalid", 32'(bvalid), 32'd1);
        checkOutput("t5c_rvalid", 32'(rvalid), 32'd1);
        checkOutput("t5c_rdata_old", rdata, 32'h0);
        checkOutput("t5c_reg5_new", regs_flat[160 +: 32], model[5]);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        checkOutput("t5c_bvalid_done", 32'(bvalid), 32'd0);
        checkOutput("t5c_rvalid_done", 32'(rvalid), 32'd0);
        readCheck(32'h14, 32'h77777777, 2'b00, "t5c_rd");

        // B backpressure
        applyStimulus(1'b1, 32'h10, 1'b1, 32'hCAFEF00D, 4'hF);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        tick();
        model[4] = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("t5b_bvalid_c%0d", c), 32'(bvalid), 32'd1);
            checkOutput($sformatf("t5b_bresp_c%0d", c), 32'(bresp), 32'd0);
            checkOutput($sformatf("t5b_awready_c%0d", c), 32'(awready), 32'd0);
            checkOutput($sformatf("t5b_wready_c%0d", c), 32'(wready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("t5b_bvalid_done", 32'(bvalid), 32'd0);
        checkOutput("t5b_awready_back", 32'(awready), 32'd1);

        // R backpressure
        araddr  = 32'h10;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("t5r_rvalid_c%0d", c), 32'(rvalid), 32'd1);
            checkOutput($sformatf("t5r_rdata_c%0d", c), rdata, 32'hCAFEF00D);
            checkOutput($sformatf("t5r_arready_c%0d", c), 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput("t5r_rvalid_done", 32'(rvalid), 32'd0);
        checkOutput("t5r_arready_back", 32'(arready), 32'd1);

        // reset one cycle after the AW handshake, before W
        applyStimulus(1'b1, 32'h04, 1'b0, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
        checkOutput("t6_bvalid", 32'(bvalid), 32'd0);
        checkOutput("t6_awready", 32'(awready), 32'd0);
        checkOutput("t6_wready", 32'(wready), 32'd0);
        checkOutput("t6_arready", 32'(arready), 32'd0);
        checkRegs("t6");
        rst = 1'b0;
        tick();
        checkOutput("t6_awready_back", 32'(awready), 32'd1);
        checkOutput("t6_wready_back", 32'(wready), 32'd1);
        checkOutput("t6_arready_back", 32'(arready), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h0BADF00D, 4'hF);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        tick();
        checkOutput("t6_no_stale_aw", 32'(bvalid), 32'd0);
        checkOutput("t6_awready_idle", 32'(awready), 32'd1);
        applyStimulus(1'b1, 32'h04, 1'b0, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        tick();
        model[1] = 32'h0BADF00D;
        checkOutput("t6_bvalid_new", 32'(bvalid), 32'd1);
        checkOutput("t6_pulse_new", 32'(wr_pulse), 32'h02);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        readCheck(32'h04, 32'h0BADF00D, 2'b00, "t6_rd");
        checkRegs("t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder (slave) that terminates transactions issued by the team's axi_master. It implements a bank of NUM_REGS 32-bit read/write registers with byte strobes, and returns OKAY or SLVERR responses. Register contents are exported to fabric logic, along with per-register write pulses. The block is the slave endpoint used in the master/slave loopback bench and in the SoC peripheral region.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, data width; fixed at 32, with byte lanes = DATA_WIDTH/8
NUM_REGS, 8, number of registers; power of two, range 2..256

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  write byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
regs_flat  out  NUM_REGS*DATA_WIDTH  all registers; reg i at bits [i*32 +: 32]
wr_pulse  out  NUM_REGS  one-cycle pulse on the register written

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all registers, rdata, and wr_pulse are 0. awready, wready, arready, bvalid, and rvalid are 0. bresp and rresp are 2'b00. All ready outputs are registered and go high on the first cycle after rst deasserts.
- Address decode:
  - word index = addr[2 +: log2(NUM_REGS)]. addr[1:0] is ignored.
  - An address >= NUM_REGS*4 is out of range.
- Write path, state machine W_IDLE -> W_RESP:
  - In W_IDLE, awready is high until AW is captured and wready is high until W is captured.
  - AW and W may be accepted in either order or in the same cycle. A captured channel deasserts its own ready.
  - The cycle after both channels are held is the commit cycle:
    - in range: register bytes are updated where wstrb=1, wr_pulse[idx]=1 for exactly that cycle, bresp=OKAY (2'b00);
    - out of range: no update, no pulse, bresp=SLVERR (2'b10).
  - bvalid rises in the commit cycle and the state moves to W_RESP.
  - In W_RESP, awready and wready are 0. bvalid and bresp hold until bvalid&&bready. The state then returns to W_IDLE, with readies high the next cycle.
  - Write latency: the response appears 1 cycle after the later of the AW/W handshakes.
- Read path, state machine R_IDLE -> R_DATA, independent of the write path:
  - In R_IDLE, arready=1. On arvalid&&arready, rdata/rresp are registered and rvalid=1 on the next cycle. rdata is the register value in range (OKAY), or 0 out of range (SLVERR).
  - In R_DATA, arready=0. rvalid, rdata, and rresp hold until rready.
- Simultaneous events:
  - If a write commit and an AR handshake fall in the same cycle on the same register, the read returns the old value.
  - Read and write progress concurrently; neither takes priority or stalls the other.
- One outstanding transaction per direction. wstrb=0 commits nothing but still pulses wr_pulse and returns OKAY.
- Reset mid-transaction: rst aborts any partially captured AW/W and any pending B/R response. No partial register update occurs, and all outputs return to their reset values.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10 (RESP_EXOKAY/DECERR reserved);
  - write FSM encoding W_IDLE, W_RESP;
  - read FSM encoding R_IDLE, R_DATA;
  - constant ADDR_LSB=2.
- Sub-module axi_lite_regfile: register array with strobe merge, single write port, combinational read port, regs_flat export. The handshake FSMs stay in the top module.

Test Plan:
- AW first, W 2 cycles later: awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF.
  -> bvalid 1 cycle after the W handshake, bresp=00, wr_pulse=8'b0000_0010. A read of 0x04 returns 0xDEADBEEF with rresp=00.
- W before AW, same data to 0x1C; then AW and W in the same cycle to 0x08 with 0x12345678.
  -> reg7=0xDEADBEEF, reg2=0x12345678, and each response arrives 1 cycle after the final handshake.
- Partial strobe: reg1=0xDEADBEEF, then write 0xAAAA5555 with wstrb=4'b0011.
  -> reg1 reads 0xDEAD5555.
- Out of range with NUM_REGS=8: write 0x20 with 0xFFFFFFFF, then read 0x40.
  -> bresp=10 with no register change and no wr_pulse; rresp=10 with rdata=0.
- Backpressure: hold bready=0 for 3 cycles after bvalid, and rready=0 for 3 cycles after rvalid.
  -> bvalid, bresp, rvalid, and rdata are stable. awready, wready, and arready stay 0 until the respective handshake completes.
- Reset mid-write: assert rst 1 cycle after the AW handshake, before W is sent.
  -> No register changes and bvalid=0. Readies return to 1 one cycle after rst deasserts, and a new write to 0x04 completes normally.
